// File: rtl/arb_resp_return_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_resp_return_router_pkg
// Description : Shared sizing helpers for the response return router.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_resp_return_router_pkg;

    localparam int C_DFLT_REQUESTER_NUM   = 3;
    localparam int C_DFLT_NUM_GRANT_REQ_W = 4;
    localparam int C_DFLT_DATA_W          = 32;
    localparam int C_DFLT_FIFO_DEPTH      = 4;

    // Requester index width; a single requester still needs one bit of storage.
    function automatic int calc_req_num_w(input int req_num);
        return (req_num > 1) ? $clog2(req_num) : 1;
    endfunction

    function automatic int calc_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int calc_entry_w(input int req_num, input int len_w);
        return calc_req_num_w(req_num) + len_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arb_order_fifo
// Description : Synchronous first-word-fall-through FIFO holding grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_order_fifo
    import arb_resp_return_router_pkg::*;
#(
    parameter  int P_WIDTH = 6,
    parameter  int P_DEPTH = 4,
    localparam int PTR_W   = calc_ptr_w(P_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [P_WIDTH-1:0] i_din,
    output logic [P_WIDTH-1:0] o_dout,
    output logic               o_full,
    output logic               o_empty,
    output logic [PTR_W-1:0]   o_count
);

    localparam int AW = PTR_W - 1;

    logic [P_WIDTH-1:0] r_mem [P_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic               w_push;
    logic               w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/arb_resp_return_router.sv
`default_nettype none
// ============================================================================
// Module      : arb_resp_return_router
// Description : Routes returning response beats to requesters in grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_resp_return_router
    import arb_resp_return_router_pkg::*;
#(
    parameter int P_REQUESTER_NUM   = C_DFLT_REQUESTER_NUM,
    parameter int P_NUM_GRANT_REQ_W = C_DFLT_NUM_GRANT_REQ_W,
    parameter int P_DATA_W          = C_DFLT_DATA_W,
    parameter int P_FIFO_DEPTH      = C_DFLT_FIFO_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [P_REQUESTER_NUM-1:0]          grant_valid_i,
    input  logic [P_NUM_GRANT_REQ_W-1:0]        num_grant_req_i,
    output logic                                grant_ready_o,
    input  logic                                resp_valid_i,
    input  logic [P_DATA_W-1:0]                 resp_data_i,
    output logic                                resp_ready_o,
    output logic [P_REQUESTER_NUM-1:0]          resp_valid_o,
    output logic [P_DATA_W-1:0]                 resp_data_o,
    output logic                                resp_last_o,
    input  logic [P_REQUESTER_NUM-1:0]          resp_ready_i,
    output logic [$clog2(P_FIFO_DEPTH):0]       outstanding_o
);

    localparam int REQ_NUM_W = calc_req_num_w(P_REQUESTER_NUM);
    localparam int ENTRY_W   = calc_entry_w(P_REQUESTER_NUM, P_NUM_GRANT_REQ_W);
    localparam int PTR_W     = calc_ptr_w(P_FIFO_DEPTH);

    logic [REQ_NUM_W-1:0]         w_grant_idx;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_beat;
    logic                         w_full;
    logic                         w_empty;
    logic [ENTRY_W-1:0]           w_din;
    logic [ENTRY_W-1:0]           w_head;
    logic [REQ_NUM_W-1:0]         w_head_idx;
    logic [P_NUM_GRANT_REQ_W-1:0] w_head_len;
    logic [PTR_W-1:0]             w_count;
    logic                         w_sel_ready;
    logic [P_REQUESTER_NUM-1:0]   w_valid;
    logic [P_NUM_GRANT_REQ_W-1:0] r_beat_cnt;

    // Lowest set bit wins, so a multi-hot grant still yields a defined index.
    always_comb begin
        w_grant_idx = '0;
        for (int k = P_REQUESTER_NUM - 1; k >= 0; k--) begin
            if (grant_valid_i[k]) w_grant_idx = REQ_NUM_W'(k);
        end
    end

    assign grant_ready_o = ~w_full;
    assign w_push        = (|grant_valid_i) & ~w_full;
    assign w_din         = {w_grant_idx, num_grant_req_i};

    arb_order_fifo #(
        .P_WIDTH (ENTRY_W),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_order_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head_idx = w_head[ENTRY_W-1:P_NUM_GRANT_REQ_W];
    assign w_head_len = w_head[P_NUM_GRANT_REQ_W-1:0];

    always_comb begin
        w_sel_ready = 1'b0;
        w_valid     = '0;
        for (int k = 0; k < P_REQUESTER_NUM; k++) begin
            if (w_head_idx == REQ_NUM_W'(k)) begin
                w_sel_ready = resp_ready_i[k];
                w_valid[k]  = resp_valid_i & ~w_empty;
            end
        end
    end

    assign resp_valid_o  = w_valid;
    assign resp_ready_o  = ~w_empty & w_sel_ready;
    assign resp_data_o   = resp_data_i;
    assign resp_last_o   = ~w_empty & (r_beat_cnt == w_head_len);
    assign outstanding_o = w_count;

    assign w_beat = resp_valid_i & resp_ready_o;
    assign w_pop  = w_beat & resp_last_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_beat) begin
            r_beat_cnt <= resp_last_o ? '0 : r_beat_cnt + P_NUM_GRANT_REQ_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arb_resp_return_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_resp_return_router
// Description : Self-checking bench for arb_resp_return_router.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_resp_return_router;

    localparam int N     = 3;
    localparam int LW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    bit            clk = 1'b0;
    logic          rst;
    logic [N-1:0]  grant_valid_i;
    logic [LW-1:0] num_grant_req_i;
    logic          grant_ready_o;
    logic          resp_valid_i;
    logic [DW-1:0] resp_data_i;
    logic          resp_ready_o;
    logic [N-1:0]  resp_valid_o;
    logic [DW-1:0] resp_data_o;
    logic          resp_last_o;
    logic [N-1:0]  resp_ready_i;
    logic [CW-1:0] outstanding_o;

    int n_total = 0;
    int n_bad   = 0;
    bit model_en = 1'b0;

    typedef struct {
        int idx;
        int len;
    } ent_t;

    ent_t q[$];
    int   beats_done = 0;

    always #5 clk = ~clk;

    arb_resp_return_router #(
        .P_REQUESTER_NUM   (N),
        .P_NUM_GRANT_REQ_W (LW),
        .P_DATA_W          (DW),
        .P_FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .grant_valid_i   (grant_valid_i),
        .num_grant_req_i (num_grant_req_i),
        .grant_ready_o   (grant_ready_o),
        .resp_valid_i    (resp_valid_i),
        .resp_data_i     (resp_data_i),
        .resp_ready_o    (resp_ready_o),
        .resp_valid_o    (resp_valid_o),
        .resp_data_o     (resp_data_o),
        .resp_last_o     (resp_last_o),
        .resp_ready_i    (resp_ready_i),
        .outstanding_o   (outstanding_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a queue of outstanding grants plus beats returned for the head.
    always @(negedge clk) begin
        if (model_en) begin
            logic [N-1:0] exp_v;
            logic         exp_rdy;
            logic         exp_last;
            int           gidx;
            exp_v    = '0;
            exp_rdy  = 1'b0;
            exp_last = 1'b0;
            if (q.size() > 0) begin
                exp_rdy  = resp_ready_i[q[0].idx];
                exp_last = (beats_done == q[0].len);
                if (resp_valid_i) exp_v[q[0].idx] = 1'b1;
            end
            check("m_grant_ready", 64'(grant_ready_o), 64'(q.size() < DEPTH));
            check("m_outstanding", 64'(outstanding_o), 64'(q.size()));
            check("m_resp_ready",  64'(resp_ready_o),  64'(exp_rdy));
            check("m_resp_valid",  64'(resp_valid_o),  64'(exp_v));
            check("m_resp_last",   64'(resp_last_o),   64'(exp_last));
            check("m_resp_data",   64'(resp_data_o),   64'(resp_data_i));

            if (rst) begin
                q.delete();
                beats_done = 0;
            end else begin
                int sz_before;
                sz_before = q.size();
                if (resp_valid_i && exp_rdy) begin
                    if (exp_last) begin
                        void'(q.pop_front());
                        beats_done = 0;
                    end else begin
                        beats_done++;
                    end
                end
                if ((|grant_valid_i) && (sz_before < DEPTH)) begin
                    gidx = 0;
                    for (int k = N - 1; k >= 0; k--) if (grant_valid_i[k]) gidx = k;
                    q.push_back('{idx: gidx, len: int'(num_grant_req_i)});
                end
            end
        end
    end

    initial begin
        logic [N-1:0] seq_v [6];
        logic         seq_l [6];
        seq_v = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b010};
        seq_l = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst             = 1'b1;
        grant_valid_i   = '0;
        num_grant_req_i = '0;
        resp_valid_i    = 1'b0;
        resp_data_i     = '0;
        resp_ready_i    = '1;
        step();
        rst      = 1'b0;
        model_en = 1'b1;
        #1;
        check("rst_grant_ready", 64'(grant_ready_o), 64'd1);
        check("rst_outstanding", 64'(outstanding_o), 64'd0);
        check("rst_resp_ready",  64'(resp_ready_o),  64'd0);
        check("rst_resp_valid",  64'(resp_valid_o),  64'd0);
        check("rst_resp_last",   64'(resp_last_o),   64'd0);

        // Single grant, single beat
        grant_valid_i = 3'b010; num_grant_req_i = 4'd0;
        step();
        grant_valid_i = '0; resp_valid_i = 1'b1; resp_data_i = 32'hA5;
        #1;
        check("t1_outstanding", 64'(outstanding_o), 64'd1);
        check("t1_valid",       64'(resp_valid_o),  64'b010);
        check("t1_last",        64'(resp_last_o),   64'd1);
        check("t1_data",        64'(resp_data_o),   64'hA5);
        step();
        resp_valid_i = 1'b0;
        #1;
        check("t1_popped", 64'(outstanding_o), 64'd0);

        // Interleaved grants returned back-to-back
        grant_valid_i = 3'b001; num_grant_req_i = 4'd2; step();
        grant_valid_i = 3'b100; num_grant_req_i = 4'd0; step();
        grant_valid_i = 3'b010; num_grant_req_i = 4'd1; step();
        grant_valid_i = '0; resp_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            resp_data_i = 32'(i + 32'h100);
            #1;
            check("t2_valid", 64'(resp_valid_o), 64'(seq_v[i]));
            check("t2_last",  64'(resp_last_o),  64'(seq_l[i]));
            step();
        end
        resp_valid_i = 1'b0;
        #1;
        check("t2_drained", 64'(outstanding_o), 64'd0);

        // Backpressure on the selected requester
        grant_valid_i = 3'b100; num_grant_req_i = 4'd1; step();
        grant_valid_i = '0; resp_valid_i = 1'b1; resp_ready_i = 3'b011;
        #1;
        check("t3_blocked", 64'(resp_ready_o), 64'd0);
        step();
        check("t3_held_last", 64'(resp_last_o), 64'd0);
        resp_ready_i = 3'b111;
        #1;
        check("t3_ready", 64'(resp_ready_o), 64'd1);
        step();
        check("t3_last", 64'(resp_last_o), 64'd1);
        step();
        resp_valid_i = 1'b0;
        #1;
        check("t3_popped", 64'(outstanding_o), 64'd0);

        // Fill to full, then release one slot
        for (int i = 0; i < 4; i++) begin
            grant_valid_i = 3'(1 << (i % N)); num_grant_req_i = 4'd0; step();
        end
        grant_valid_i = '0;
        #1;
        check("t4_full_ready", 64'(grant_ready_o), 64'd0);
        check("t4_full_cnt",   64'(outstanding_o), 64'd4);
        resp_valid_i = 1'b1;
        step();
        resp_valid_i = 1'b0;
        #1;
        check("t4_ready_again", 64'(grant_ready_o), 64'd1);
        check("t4_cnt",         64'(outstanding_o), 64'd3);
        resp_valid_i = 1'b1;
        repeat (3) step();
        #1;
        check("t4_empty", 64'(outstanding_o), 64'd0);

        // Empty stall, then push during the final pop
        #1;
        check("t5_stall_ready", 64'(resp_ready_o), 64'd0);
        check("t5_stall_valid", 64'(resp_valid_o), 64'd0);
        resp_valid_i  = 1'b0;
        grant_valid_i = 3'b001; num_grant_req_i = 4'd0; step();
        grant_valid_i = 3'b010; resp_valid_i = 1'b1; step();
        grant_valid_i = '0; resp_valid_i = 1'b0;
        #1;
        check("t5_simul_cnt", 64'(outstanding_o), 64'd1);
        resp_valid_i = 1'b1; step(); resp_valid_i = 1'b0;

        // Reset in the middle of a burst
        grant_valid_i = 3'b010; num_grant_req_i = 4'd3; step();
        grant_valid_i = '0; resp_valid_i = 1'b1; step(); step();
        resp_valid_i = 1'b0; rst = 1'b1; step();
        rst = 1'b0;
        #1;
        check("t6_cnt",         64'(outstanding_o), 64'd0);
        check("t6_grant_ready", 64'(grant_ready_o), 64'd1);
        check("t6_resp_ready",  64'(resp_ready_o),  64'd0);
        grant_valid_i = 3'b001; num_grant_req_i = 4'd0; step();
        grant_valid_i = '0; resp_valid_i = 1'b1;
        #1;
        check("t6_valid", 64'(resp_valid_o), 64'b001);
        check("t6_last",  64'(resp_last_o),  64'd1);
        step();
        resp_valid_i = 1'b0;

        // Randomized traffic against the queue model
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 2) == 0) begin
                grant_valid_i = ($urandom_range(0, 9) == 0) ? 3'($urandom)
                                                             : 3'(1 << $urandom_range(0, N - 1));
            end else begin
                grant_valid_i = '0;
            end
            num_grant_req_i = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            resp_valid_i    = ($urandom_range(0, 3) != 0);
            resp_data_i     = $urandom;
            resp_ready_i    = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111;
            step();
        end
        rst = 1'b0; grant_valid_i = '0; resp_valid_i = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arb_resp_return_router.md
Name: arb_resp_return_router

Overview:
- Return-path companion to the interleaved weighted round-robin arbiter in the AXI4 interconnect.
- On each accepted grant, records the granted requester index and burst length in an order FIFO.
- Routes returning response beats, such as B or R, from the shared downstream port back to the originating requester, in grant order.
- Pops an entry once that grant's full beat count has been returned.

Parameters:
- P_REQUESTER_NUM, 3, number of requesters; matches the arbiter instance.
- P_NUM_GRANT_REQ_W, 4, width of the per-grant length field; beats per grant = num_grant_req_i + 1.
- P_DATA_W, 32, response payload width.
- P_FIFO_DEPTH, 4, outstanding grants tracked; must be a power of 2 and at least 2.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- grant_valid_i, in, P_REQUESTER_NUM, one-hot grant from the arbiter.
- num_grant_req_i, in, P_NUM_GRANT_REQ_W, length of this grant minus 1.
- grant_ready_o, out, 1, order FIFO can accept a grant; drives the arbiter's grant_ready_i.
- resp_valid_i, in, 1, downstream response valid.
- resp_data_i, in, P_DATA_W, downstream response payload.
- resp_ready_o, out, 1, response accepted.
- resp_valid_o, out, P_REQUESTER_NUM, per-requester response valid.
- resp_data_o, out, P_DATA_W, payload broadcast to all requesters.
- resp_last_o, out, 1, current beat is the final beat of the head grant.
- resp_ready_i, in, P_REQUESTER_NUM, per-requester ready.
- outstanding_o, out, $clog2(P_FIFO_DEPTH)+1, number of FIFO entries.

Behaviour:
- Reset: one clock with rst=1 at the edge.
  - Clears the FIFO pointers, beat_cnt and outstanding_o to 0.
  - After reset, grant_ready_o=1 and resp_valid_o, resp_ready_o and resp_last_o are 0.
  - Reset asserted mid-burst discards all entries; a partially returned burst is dropped and nothing is replayed.
- Grant push:
  - Occurs when (|grant_valid_i) && grant_ready_o.
  - Stored entry is {idx, len}. idx is the lowest set bit of grant_valid_i. Multi-hot input is a protocol error; lowest-index-wins is the defined result.
  - len = num_grant_req_i.
  - grant_ready_o = ~full, registered-state based, with no combinational path from any input.
- Head routing: combinational from registered head, beat_cnt and the response inputs.
  - resp_valid_o[k] = resp_valid_i && ~empty && (head.idx==k).
  - resp_ready_o = ~empty && resp_ready_i[head.idx].
  - resp_data_o = resp_data_i.
  - resp_last_o = ~empty && (beat_cnt==head.len).
- Empty FIFO:
  - resp_ready_o=0 and all resp_valid_o=0; an incoming response stalls.
  - There is no bypass. The earliest a response can be accepted is the cycle after its grant push (1-cycle latency).
- Beat handshake: occurs when resp_valid_i && resp_ready_o.
  - If beat_cnt==head.len: pop the head and set beat_cnt to 0.
  - Otherwise beat_cnt increments by 1.
  - beat_cnt width is P_NUM_GRANT_REQ_W and never wraps past len.
- Simultaneous push and pop:
  - Both take effect and outstanding_o is unchanged.
  - When full, a pop in the same cycle does not enable a push, because grant_ready_o reflects only registered full.
- Pointers: wrap-around uses $clog2(P_FIFO_DEPTH)+1-bit pointers; full/empty comes from the MSB-differ compare.
- Ordering: strictly in grant order, with no reordering across requesters.

Decomposition:
- Shared header holds localparams:
  - REQ_NUM_W = $clog2(P_REQUESTER_NUM) (same definition as the arbiter).
  - ENTRY_W = REQ_NUM_W + P_NUM_GRANT_REQ_W.
  - Pointer width.
- One sub-module: arb_order_fifo. It is a synchronous FIFO with synchronous active-high reset.
  - Parameters: width ENTRY_W, depth P_FIFO_DEPTH.
  - Ports: push, pop, din, dout (head, first-word-fall-through), full, empty, count.
- The top module owns the one-hot encoder, beat counter and demux.

Test Plan:
- Single grant, single beat (N=3): grant_valid_i=3'b010, len=0; next cycle resp_valid_i=1, data=0xA5.
  - Expect resp_valid_o=3'b010, resp_last_o=1 and a pop.
  - outstanding_o goes 1 then 0.
- Interleaved grants: push 3'b001 len=2, then 3'b100 len=0, then 3'b010 len=1; return 6 beats back-to-back.
  - Expect resp_valid_o sequence 001,001,001,100,010,010.
  - resp_last_o on beats 3, 4 and 6.
- Backpressure: head idx=2, len=1, resp_ready_i=3'b011.
  - Expect resp_ready_o=0 and beat_cnt held.
  - Raise resp_ready_i[2]: 2 beats accepted, then the entry pops.
- Full/wrap: push 4 grants without responses.
  - Expect grant_ready_o=0 and outstanding_o=4.
  - Pop one: grant_ready_o=1 the next cycle.
  - Cycle through 10 grants to exercise pointer wrap; order is preserved.
- Empty stall and simultaneous push/pop:
  - resp_valid_i=1 with an empty FIFO: resp_ready_o=0 and resp_valid_o=0.
  - Grant push in the cycle the last beat pops: outstanding_o stays 1.
- Reset mid-burst: head len=3 after 2 beats accepted, then rst=1 for one cycle.
  - Expect outstanding_o=0, grant_ready_o=1 and resp_ready_o=0.
  - A new grant 3'b001 len=0 routes correctly, with beat_cnt starting at 0.
